// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register: captures the decoded bundle, builds ALU operands and resolves RAW hazards.
// Optional macro EX_OPERAND_BYPASS_EN enables the EX/MEM/WB bypass network (otherwise every RAW hazard stalls).
module ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              id_valid_i,
  output logic              ex_allowin_o,
  output logic              id_stall_o,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [DATA_W-1:0] id_rs_val_i,
  input  logic [DATA_W-1:0] id_rt_val_i,
  input  logic [15:0]       id_imm_i,
  input  logic [4:0]        id_shamt_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [1:0]        id_src1_sel_i,
  input  logic [1:0]        id_src2_sel_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_we_i,
  input  logic              id_is_load_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              mem_allowin_i,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              wb_valid_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [REG_AW-1:0] ex_dest_o,
  output logic              ex_we_o,
  output logic              ex_is_load_o,
  output logic [DATA_W-1:0] ex_pc_o
);

  localparam int unsigned IMM_W = 16;

  logic              ex_rs_c, ex_rt_c, mem_rs_c, mem_rt_c, wb_rs_c, wb_rt_c;
  logic              hazard_c;
  logic              capture_c;
  logic [DATA_W-1:0] rs_fwd_c, rt_fwd_c;
  logic [DATA_W-1:0] src1_c, src2_c;

  // Producer match on a source register; register 0 never matches.
  function automatic logic src_match(input logic              used,
                                     input logic [REG_AW-1:0] idx,
                                     input logic              pvalid,
                                     input logic              pwe,
                                     input logic [REG_AW-1:0] pdest);
    return used && (idx != '0) && pvalid && pwe && (pdest == idx);
  endfunction

  assign ex_rs_c  = src_match(id_uses_rs_i, id_rs_i, ex_valid_o,  ex_we_o,  ex_dest_o);
  assign ex_rt_c  = src_match(id_uses_rt_i, id_rt_i, ex_valid_o,  ex_we_o,  ex_dest_o);
  assign mem_rs_c = src_match(id_uses_rs_i, id_rs_i, mem_valid_i, mem_we_i, mem_dest_i);
  assign mem_rt_c = src_match(id_uses_rt_i, id_rt_i, mem_valid_i, mem_we_i, mem_dest_i);
  assign wb_rs_c  = src_match(id_uses_rs_i, id_rs_i, wb_valid_i,  wb_we_i,  wb_dest_i);
  assign wb_rt_c  = src_match(id_uses_rt_i, id_rt_i, wb_valid_i,  wb_we_i,  wb_dest_i);

`ifdef EX_OPERAND_BYPASS_EN
  // Youngest producer wins: EX, then MEM, then WB, then the regfile read.
  always_comb begin
    rs_fwd_c = id_rs_val_i;
    rt_fwd_c = id_rt_val_i;
    if (ex_rs_c)       rs_fwd_c = alu_result_i;
    else if (mem_rs_c) rs_fwd_c = mem_wdata_i;
    else if (wb_rs_c)  rs_fwd_c = wb_wdata_i;
    if (ex_rt_c)       rt_fwd_c = alu_result_i;
    else if (mem_rt_c) rt_fwd_c = mem_wdata_i;
    else if (wb_rt_c)  rt_fwd_c = wb_wdata_i;
  end

  // Load data is not available until MEM, so only load-use needs a bubble.
  assign hazard_c = (ex_rs_c | ex_rt_c) & ex_is_load_o;
`else
  logic unused_bypass_c;

  assign rs_fwd_c        = id_rs_val_i;
  assign rt_fwd_c        = id_rt_val_i;
  assign hazard_c        = ex_rs_c | ex_rt_c | mem_rs_c | mem_rt_c | wb_rs_c | wb_rt_c;
  assign unused_bypass_c = ^{alu_result_i, mem_wdata_i, wb_wdata_i};
`endif

  assign id_stall_o   = id_valid_i & ~flush_i & hazard_c;
  assign ex_allowin_o = ~ex_valid_o | mem_allowin_i;
  assign capture_c    = id_valid_i & ex_allowin_o & ~id_stall_o & ~flush_i;

  // First ALU operand.
  always_comb begin
    src1_c = '0;
    case (id_src1_sel_i)
      2'd0:    src1_c = rs_fwd_c;
      2'd1:    src1_c = DATA_W'(id_shamt_i);
      2'd2:    src1_c = id_pc_i;
      default: src1_c = '0;
    endcase
  end

  // Second ALU operand; constant 8 is the link-address offset.
  always_comb begin
    src2_c = '0;
    case (id_src2_sel_i)
      2'd0:    src2_c = rt_fwd_c;
      2'd1:    src2_c = {{(DATA_W-IMM_W){id_imm_i[IMM_W-1]}}, id_imm_i};
      2'd2:    src2_c = DATA_W'(id_imm_i);
      default: src2_c = DATA_W'(8);
    endcase
  end

  // Stage register: reset > flush > (allowin ? capture/bubble : hold).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid_o   <= 1'b0;
      alu_ctrl_o   <= '0;
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      ex_dest_o    <= '0;
      ex_we_o      <= 1'b0;
      ex_is_load_o <= 1'b0;
      ex_pc_o      <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (ex_allowin_o) begin
      ex_valid_o <= capture_c;
      if (capture_c) begin
        alu_ctrl_o   <= id_alu_ctrl_i;
        alu_src1_o   <= src1_c;
        alu_src2_o   <= src2_c;
        ex_dest_o    <= id_dest_i;
        ex_we_o      <= id_we_i;
        ex_is_load_o <= id_is_load_i;
        ex_pc_o      <= id_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow the EX_OPERAND_BYPASS_EN setting of the build.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, flush_i, id_valid_i;
  logic        ex_allowin_o, id_stall_o;
  logic [11:0] id_alu_ctrl_i;
  logic [4:0]  id_rs_i, id_rt_i;
  logic        id_uses_rs_i, id_uses_rt_i;
  logic [31:0] id_rs_val_i, id_rt_val_i;
  logic [15:0] id_imm_i;
  logic [4:0]  id_shamt_i;
  logic [31:0] id_pc_i;
  logic [1:0]  id_src1_sel_i, id_src2_sel_i;
  logic [4:0]  id_dest_i;
  logic        id_we_i, id_is_load_i;
  logic [31:0] alu_result_i;
  logic        mem_allowin_i, mem_valid_i, mem_we_i;
  logic [4:0]  mem_dest_i;
  logic [31:0] mem_wdata_i;
  logic        wb_valid_i, wb_we_i;
  logic [4:0]  wb_dest_i;
  logic [31:0] wb_wdata_i;
  logic        ex_valid_o;
  logic [11:0] alu_ctrl_o;
  logic [31:0] alu_src1_o, alu_src2_o;
  logic [4:0]  ex_dest_o;
  logic        ex_we_o, ex_is_load_o;
  logic [31:0] ex_pc_o;

  ex_operand_stage dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .ex_allowin_o(ex_allowin_o), .id_stall_o(id_stall_o), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_rs_val_i(id_rs_val_i), .id_rt_val_i(id_rt_val_i), .id_imm_i(id_imm_i),
    .id_shamt_i(id_shamt_i), .id_pc_i(id_pc_i), .id_src1_sel_i(id_src1_sel_i),
    .id_src2_sel_i(id_src2_sel_i), .id_dest_i(id_dest_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .alu_result_i(alu_result_i), .mem_allowin_i(mem_allowin_i),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_dest_i(mem_dest_i),
    .mem_wdata_i(mem_wdata_i), .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i),
    .wb_dest_i(wb_dest_i), .wb_wdata_i(wb_wdata_i), .ex_valid_o(ex_valid_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .ex_dest_o(ex_dest_o), .ex_we_o(ex_we_o), .ex_is_load_o(ex_is_load_o), .ex_pc_o(ex_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] ctrl;
    logic [4:0]  dest;
    logic        we;
    logic        ld;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] c,
                              input logic [4:0] d, input logic we, input logic ld, input logic [31:0] pc);
    exp_t e;
    e.src1 = s1; e.src2 = s2; e.ctrl = c; e.dest = d; e.we = we; e.ld = ld; e.pc = pc;
    return e;
  endfunction

  task automatic drive(input logic [11:0] c, input logic [4:0] rs, input logic urs, input logic [31:0] rsv,
                       input logic [4:0] rt, input logic urt, input logic [31:0] rtv,
                       input logic [15:0] imm, input logic [4:0] sh, input logic [31:0] pc,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [4:0] d, input logic we, input logic ld);
    id_valid_i = 1'b1; id_alu_ctrl_i = c;
    id_rs_i = rs; id_uses_rs_i = urs; id_rs_val_i = rsv;
    id_rt_i = rt; id_uses_rt_i = urt; id_rt_val_i = rtv;
    id_imm_i = imm; id_shamt_i = sh; id_pc_i = pc;
    id_src1_sel_i = s1; id_src2_sel_i = s2;
    id_dest_i = d; id_we_i = we; id_is_load_i = ld;
  endtask

  // Clock once; a valid stage output consumes the oldest scoreboard entry.
  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (ex_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_valid"}, 32'(ex_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_src1"}, alu_src1_o, e.src1);
        chk({tag, "_src2"}, alu_src2_o, e.src2);
        chk({tag, "_ctrl"}, 32'(alu_ctrl_o), 32'(e.ctrl));
        chk({tag, "_dest"}, 32'(ex_dest_o), 32'(e.dest));
        chk({tag, "_we"}, 32'(ex_we_o), 32'(e.we));
        chk({tag, "_load"}, 32'(ex_is_load_o), 32'(e.ld));
        chk({tag, "_pc"}, ex_pc_o, e.pc);
      end
    end else begin
      chk({tag, "_missing_output"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Check the stall decision, record the expected capture, then clock and compare.
  task automatic issue(input string tag, input logic exp_stall, input exp_t e);
    #1;
    chk({tag, "_stall"}, 32'(id_stall_o), 32'(exp_stall));
    if (!exp_stall && !flush_i && id_valid_i) sb.push_back(e);
    step_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; flush_i = 1'b0; mem_allowin_i = 1'b1; alu_result_i = '0;
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_dest_i = '0; mem_wdata_i = '0;
    wb_valid_i = 1'b0; wb_we_i = 1'b0; wb_dest_i = '0; wb_wdata_i = '0;
    drive(12'h001, 5'd1, 1'b1, 32'd2, 5'd2, 1'b1, 32'd3, 16'h0, 5'd0, 32'h100, 2'd0, 2'd0, 5'd3, 1'b1, 1'b0);

    // Reset held two cycles with a valid bundle presented
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("rst_src1", alu_src1_o, 32'd0);
    chk("rst_src2", alu_src2_o, 32'd0);
    chk("rst_dest", 32'(ex_dest_o), 32'd0);
    chk("rst_we", 32'(ex_we_o), 32'd0);
    chk("rst_load", 32'(ex_is_load_o), 32'd0);
    chk("rst_pc", ex_pc_o, 32'd0);
    chk("rst_allowin", 32'(ex_allowin_o), 32'd1);
    resetn = 1'b1;

    // Back-to-back dependent addu
    issue("t2_prod", 1'b0, mk(32'd2, 32'd3, 12'h001, 5'd3, 1'b1, 1'b0, 32'h100));
    alu_result_i = 32'd5;
    drive(12'h001, 5'd3, 1'b1, 32'h77, 5'd3, 1'b1, 32'h77, 16'h0, 5'd0, 32'h104, 2'd0, 2'd0, 5'd4, 1'b1, 1'b0);
    issue("t2_cons", !BYP, mk(32'd5, 32'd5, 12'h001, 5'd4, 1'b1, 1'b0, 32'h104));
`ifndef EX_OPERAND_BYPASS_EN
    id_rs_val_i = 32'd5; id_rt_val_i = 32'd5;
    issue("t2_retry", 1'b0, mk(32'd5, 32'd5, 12'h001, 5'd4, 1'b1, 1'b0, 32'h104));
`endif

    // Load-use: lw $5 then addu $6,$5,$0
    alu_result_i = 32'h0000_000A;
    drive(12'h001, 5'd29, 1'b1, 32'h1000, 5'd5, 1'b0, 32'h0, 16'hFFFC, 5'd0, 32'h108, 2'd0, 2'd1, 5'd5, 1'b1, 1'b1);
    issue("t3_lw", 1'b0, mk(32'h1000, 32'hFFFF_FFFC, 12'h001, 5'd5, 1'b1, 1'b1, 32'h108));
    alu_result_i = 32'h0000_0FFC;
    drive(12'h001, 5'd5, 1'b1, 32'hBAD, 5'd0, 1'b1, 32'h0, 16'h0, 5'd0, 32'h10C, 2'd0, 2'd0, 5'd6, 1'b1, 1'b0);
    issue("t3_use", 1'b1, mk(32'h0, 32'h0, 12'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_dest_i = 5'd5; mem_wdata_i = 32'h1234;
`ifdef EX_OPERAND_BYPASS_EN
    issue("t3_byp", 1'b0, mk(32'h1234, 32'h0, 12'h001, 5'd6, 1'b1, 1'b0, 32'h10C));
`else
    issue("t3_mem", 1'b1, mk(32'h0, 32'h0, 12'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    mem_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_dest_i = 5'd5; wb_wdata_i = 32'h1234;
    issue("t3_wb", 1'b1, mk(32'h0, 32'h0, 12'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    wb_valid_i = 1'b0; id_rs_val_i = 32'h1234;
    issue("t3_rf", 1'b0, mk(32'h1234, 32'h0, 12'h001, 5'd6, 1'b1, 1'b0, 32'h10C));
`endif
    mem_valid_i = 1'b0; wb_valid_i = 1'b0;

    // Register 0 is never a hazard or bypass source
    drive(12'h001, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2, 16'h0, 5'd0, 32'h110, 2'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    issue("t4_prod", 1'b0, mk(32'd1, 32'd2, 12'h001, 5'd0, 1'b1, 1'b0, 32'h110));
    alu_result_i = 32'hDEAD;
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_dest_i = 5'd0; mem_wdata_i = 32'hBEEF;
    wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_dest_i = 5'd0; wb_wdata_i = 32'hCAFE;
    drive(12'h040, 5'd0, 1'b1, 32'h0, 5'd7, 1'b0, 32'h777, 16'h8001, 5'd0, 32'h114, 2'd0, 2'd2, 5'd8, 1'b1, 1'b0);
    issue("t4_zero", 1'b0, mk(32'h0, 32'h0000_8001, 12'h040, 5'd8, 1'b1, 1'b0, 32'h114));
    mem_valid_i = 1'b0; wb_valid_i = 1'b0;

    // Backpressure: pc/const-8 bundle held three cycles
    drive(12'h001, 5'd8, 1'b0, 32'h0, 5'd8, 1'b0, 32'h0, 16'h0, 5'd0, 32'h200, 2'd2, 2'd3, 5'd31, 1'b1, 1'b0);
    issue("t5_jal", 1'b0, mk(32'h200, 32'd8, 12'h001, 5'd31, 1'b1, 1'b0, 32'h200));
    mem_allowin_i = 1'b0;
    drive(12'h800, 5'd0, 1'b0, 32'h0, 5'd9, 1'b1, 32'h55, 16'h0, 5'd31, 32'h204, 2'd1, 2'd0, 5'd12, 1'b1, 1'b1);
    #1;
    chk("t5_allowin_low", 32'(ex_allowin_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", 32'(ex_valid_o), 32'd1);
      chk("t5_hold_src1", alu_src1_o, 32'h200);
      chk("t5_hold_dest", 32'(ex_dest_o), 32'd31);
      chk("t5_hold_allowin", 32'(ex_allowin_o), 32'd0);
    end
    mem_allowin_i = 1'b1;
    issue("t5_release", 1'b0, mk(32'h1F, 32'h55, 12'h800, 5'd12, 1'b1, 1'b1, 32'h204));

    // Flush clears the load-use stall and kills the captured slot
    drive(12'h001, 5'd12, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 16'h0, 5'd0, 32'h208, 2'd0, 2'd0, 5'd13, 1'b1, 1'b0);
    #1;
    chk("t6_loaduse_stall", 32'(id_stall_o), 32'd1);
    flush_i = 1'b1;
    issue("t6_flush", 1'b0, mk(32'h0, 32'h0, 12'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    flush_i = 1'b0;

    // MEM and WB producers: bypassed, or stalled without the bypass network
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_dest_i = 5'd13; mem_wdata_i = 32'h1313;
    drive(12'h002, 5'd0, 1'b0, 32'h0, 5'd13, 1'b1, 32'h0, 16'h0, 5'd0, 32'h20C, 2'd0, 2'd0, 5'd14, 1'b1, 1'b0);
    issue("t6_mem", !BYP, mk(32'h0, 32'h1313, 12'h002, 5'd14, 1'b1, 1'b0, 32'h20C));
    mem_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_dest_i = 5'd15; wb_wdata_i = 32'h1515;
    drive(12'h004, 5'd15, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 16'h0, 5'd0, 32'h210, 2'd0, 2'd0, 5'd16, 1'b1, 1'b0);
    issue("t6_wb", !BYP, mk(32'h1515, 32'h0, 12'h004, 5'd16, 1'b1, 1'b0, 32'h210));
    wb_we_i = 1'b0;
    drive(12'h004, 5'd15, 1'b1, 32'h99, 5'd0, 1'b1, 32'h0, 16'h0, 5'd0, 32'h214, 2'd0, 2'd0, 5'd17, 1'b1, 1'b0);
    issue("t6_nowe", 1'b0, mk(32'h99, 32'h0, 12'h004, 5'd17, 1'b1, 1'b0, 32'h214));

    // Priority: EX over MEM over WB
    alu_result_i = 32'hE0E0;
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_dest_i = 5'd17; mem_wdata_i = 32'hF0F0;
    wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_dest_i = 5'd17; wb_wdata_i = 32'hA0A0;
    drive(12'h001, 5'd17, 1'b1, 32'h11, 5'd17, 1'b1, 32'h11, 16'h0, 5'd0, 32'h218, 2'd0, 2'd0, 5'd18, 1'b1, 1'b0);
    issue("t6_prio_ex", !BYP, mk(32'hE0E0, 32'hE0E0, 12'h001, 5'd18, 1'b1, 1'b0, 32'h218));
    drive(12'h001, 5'd17, 1'b1, 32'h11, 5'd17, 1'b1, 32'h11, 16'h0, 5'd0, 32'h21C, 2'd0, 2'd0, 5'd19, 1'b1, 1'b0);
    issue("t6_prio_mem", !BYP, mk(32'hF0F0, 32'hF0F0, 12'h001, 5'd19, 1'b1, 1'b0, 32'h21C));

    // Idle cycle drains the stage
    mem_valid_i = 1'b0; wb_valid_i = 1'b0; id_valid_i = 1'b0;
    issue("idle", 1'b0, mk(32'h0, 32'h0, 12'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
